// File: rtl/dmem_port_arbiter.sv
// Purpose: share the single-port data RAM between the core M-stage port and one external master.
// Latency: ext grant in the request cycle when the core is idle, else within MAX_WAIT cycles; ack one cycle after grant.
// Backpressure: the core has priority; an external request that waits MAX_WAIT cycles stalls the core for exactly one cycle.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-low reset
//   cpu_addr_i/wdata_i/we_i/re_i      core data port (byte address, word bits [ADDR_W+1:2] used)
//   cpu_rdata_o, cpu_stall_o          RAM read data to the core, one-cycle freeze request
//   ext_req_i/we_i/addr_i/wdata_i     external request, fields held until ext_gnt_o
//   ext_gnt_o, ext_ack_o, ext_rdata_o grant (comb), ack pulse and captured read data (registered)
//   ram_a_o/ram_d_o/ram_we_o/ram_spo_i  RAM port (async read, sync write)
//   perf_stall_cnt_o, perf_ext_cnt_o  16-bit event counters, built only with DMEM_ARB_PERF_EN
//                                     defined; otherwise tied to zero.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              cpu_we_i,
  input  logic              cpu_re_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_gnt_o,
  output logic              ext_ack_o,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [DATA_W-1:0] ram_d_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_spo_i,
  output logic [15:0]       perf_stall_cnt_o,
  output logic [15:0]       perf_ext_cnt_o
);

  // A zero-width counter is not legal, so MAX_WAIT=0 still gets one bit.
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic             cpu_active;
  logic             grant_ok;

  // Byte-offset and high address bits of the core address never reach the RAM.
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^{cpu_addr_i[31:ADDR_W+2], cpu_addr_i[1:0]};

  always_comb begin
    cpu_active = cpu_we_i | cpu_re_i;
    // Folding rst_i in here keeps grant, stall and the external write quiet during reset.
    grant_ok   = rst_i & ext_req_i & (state != S_ACK) &
                 (~cpu_active | (wait_cnt == MAX_CNT));

    state_nxt  = state;
    wait_nxt   = wait_cnt;
    case (state)
      S_IDLE: begin
        if (grant_ok) begin
          state_nxt = S_ACK;
        end else if (ext_req_i) begin
          state_nxt = S_WAIT;
          wait_nxt  = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (grant_ok) begin
          state_nxt = S_ACK;
          wait_nxt  = '0;
        end else if (!ext_req_i) begin
          state_nxt = S_IDLE;
          wait_nxt  = '0;
        end else if (wait_cnt != MAX_CNT) begin
          wait_nxt  = wait_cnt + CNT_W'(1);
        end
      end
      S_ACK: begin
        // No grant here: a request still high is treated as new from S_IDLE.
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        wait_nxt  = '0;
      end
    endcase

    ext_gnt_o   = grant_ok;
    cpu_stall_o = grant_ok & cpu_active;
    ext_ack_o   = (state == S_ACK);
    cpu_rdata_o = ram_spo_i;

    // A stalled core write is masked simply because the mux hands the port to ext.
    if (grant_ok) begin
      ram_a_o  = ext_addr_i;
      ram_d_o  = ext_wdata_i;
      ram_we_o = ext_we_i;
    end else begin
      ram_a_o  = cpu_addr_i[ADDR_W+1:2];
      ram_d_o  = cpu_wdata_i;
      ram_we_o = rst_i & cpu_we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      ext_rdata_o <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      // Old RAM contents at the grant edge, so a write returns the overwritten word.
      if (grant_ok) begin
        ext_rdata_o <= ram_spo_i;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] ext_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      ext_cnt   <= '0;
    end else begin
      if (cpu_stall_o) stall_cnt <= stall_cnt + 16'd1;
      if (ext_ack_o)   ext_cnt   <= ext_cnt + 16'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt;
  assign perf_ext_cnt_o   = ext_cnt;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_ext_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus a randomized run, all checked
// against an age-based behavioural model and a reference copy of the RAM.
module tb_dmem_port_arbiter;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
  logic        cpu_we_i = 1'b0, cpu_re_i = 1'b0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        ext_req_i = 1'b0, ext_we_i = 1'b0;
  logic [7:0]  ext_addr_i = '0;
  logic [31:0] ext_wdata_i = '0;
  logic        ext_gnt_o, ext_ack_o;
  logic [31:0] ext_rdata_o;
  logic [7:0]  ram_a_o;
  logic [31:0] ram_d_o;
  logic        ram_we_o;
  logic [31:0] ram_spo_i;
  logic [15:0] perf_stall_cnt_o, perf_ext_cnt_o;

  dmem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_we_i(cpu_we_i), .cpu_re_i(cpu_re_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i), .ext_wdata_i(ext_wdata_i),
    .ext_gnt_o(ext_gnt_o), .ext_ack_o(ext_ack_o), .ext_rdata_o(ext_rdata_o),
    .ram_a_o(ram_a_o), .ram_d_o(ram_d_o), .ram_we_o(ram_we_o), .ram_spo_i(ram_spo_i),
    .perf_stall_cnt_o(perf_stall_cnt_o), .perf_ext_cnt_o(perf_ext_cnt_o)
  );

  // Environment RAM driven by the DUT.
  logic [31:0] mem [256];
  assign ram_spo_i = mem[ram_a_o];
  always @(posedge clk) if (ram_we_o) mem[ram_a_o] <= ram_d_o;

  // Behavioural model: reference RAM, age of the pending external request,
  // whether an ack is owed this cycle, and the event counts.
  logic [31:0] ref_mem [256];
  int          m_age = 0;
  bit          m_ack_due = 1'b0;
  bit          m_after_rst = 1'b0;
  logic [31:0] m_rdata = '0;
  int          m_stall_cnt = 0, m_ext_cnt = 0;

  int n_vec = 0, n_err = 0;

  // Values sampled in the most recent step, used by the literal checks.
  logic        s_gnt, s_stall, s_ack, s_we;
  logic [31:0] s_rdata, s_perf_ext;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare every output to the model, then advance the model.
  task automatic step(input logic rst, input logic c_re, input logic c_we,
                      input logic [31:0] c_addr, input logic [31:0] c_wd,
                      input logic e_req, input logic e_we,
                      input logic [7:0] e_addr, input logic [31:0] e_wd);
    logic        cpu_act, exp_gnt, exp_stall, exp_we;
    logic [7:0]  exp_a;
    logic [31:0] exp_d;
    @(negedge clk);
    rst_i = rst; cpu_re_i = c_re; cpu_we_i = c_we; cpu_addr_i = c_addr; cpu_wdata_i = c_wd;
    ext_req_i = e_req; ext_we_i = e_we; ext_addr_i = e_addr; ext_wdata_i = e_wd;
    #1;
    cpu_act   = c_re | c_we;
    exp_gnt   = rst & e_req & !m_ack_due & (!cpu_act || (m_age >= MAX_WAIT));
    exp_stall = exp_gnt & cpu_act;
    exp_a     = exp_gnt ? e_addr : c_addr[9:2];
    exp_d     = exp_gnt ? e_wd : c_wd;
    exp_we    = rst & (exp_gnt ? e_we : c_we);

    chk("gnt", ext_gnt_o, exp_gnt);
    chk("stall", cpu_stall_o, exp_stall);
    chk("ack", ext_ack_o, m_ack_due);
    if (m_ack_due || m_after_rst) chk("ext_rdata", ext_rdata_o, m_rdata);
    chk("ram_a", ram_a_o, exp_a);
    chk("ram_d", ram_d_o, exp_d);
    chk("ram_we", ram_we_o, exp_we);
    chk("cpu_rdata", cpu_rdata_o, ref_mem[exp_a]);
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall", perf_stall_cnt_o, m_stall_cnt);
    chk("perf_ext", perf_ext_cnt_o, m_ext_cnt);
`else
    chk("perf_stall", perf_stall_cnt_o, 0);
    chk("perf_ext", perf_ext_cnt_o, 0);
`endif
    s_gnt = ext_gnt_o; s_stall = cpu_stall_o; s_ack = ext_ack_o; s_we = ram_we_o;
    s_rdata = ext_rdata_o; s_perf_ext = {16'h0, perf_ext_cnt_o};

    @(posedge clk);
    if (!rst) begin
      m_age = 0; m_ack_due = 1'b0; m_rdata = '0; m_after_rst = 1'b1;
      m_stall_cnt = 0; m_ext_cnt = 0;
    end else begin
      if (exp_gnt) begin
        m_rdata = ref_mem[e_addr];
        m_after_rst = 1'b0;
      end
      if (exp_we) ref_mem[exp_a] = exp_d;
      if (exp_stall) m_stall_cnt = (m_stall_cnt + 1) & 16'hFFFF;
      if (m_ack_due) m_ext_cnt = (m_ext_cnt + 1) & 16'hFFFF;
      if (exp_gnt) m_age = 0;
      else if (e_req && !m_ack_due) m_age = (m_age + 1 > MAX_WAIT) ? MAX_WAIT : m_age + 1;
      else m_age = 0;
      m_ack_due = exp_gnt;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  logic        r_req, r_we, c_re, c_we;
  logic [7:0]  r_addr;
  logic [31:0] r_wd, c_addr;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (i * 32'h01010101) ^ 32'hA5A50000;
      ref_mem[i] = (i * 32'h01010101) ^ 32'hA5A50000;
    end

    // Reset with a pending external write and core write: nothing may be granted or written.
    step(1'b0, 1'b0, 1'b1, 32'h4, 32'h1, 1'b1, 1'b1, 8'h5, 32'h2);
    chk("rst_gnt", s_gnt, 1'b0);
    chk("rst_we", s_we, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    chk("rst_ack", s_ack, 1'b0);
    chk("rst_rdata", s_rdata, 32'h0);
    idle();

    // 1: core idle, ext write 0x10 <- DEADBEEF, granted immediately.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    chk("t1_gnt", s_gnt, 1'b1);
    chk("t1_stall", s_stall, 1'b0);
    chk("t1_we", s_we, 1'b1);
    idle();
    chk("t1_ack", s_ack, 1'b1);
    chk("t1_mem", mem[8'h10], 32'hDEADBEEF);

    // 2: core loads every cycle, ext read 0x10 granted on the 5th request cycle.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 8'h10, 32'h0);
      chk("t2_gnt", s_gnt, (k == 5));
      chk("t2_stall", s_stall, (k == 5));
    end
    step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    chk("t2_ack", s_ack, 1'b1);
    chk("t2_rdata", s_rdata, 32'hDEADBEEF);
    chk("t2_stall_after", s_stall, 1'b0);

    // 3: core store to 0x20 during the forced stall is blocked, the retry lands.
    for (int k = 1; k <= 4; k++)
      step(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 8'h03, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b1, 1'b0, 8'h03, 32'h0);
    chk("t3_gnt", s_gnt, 1'b1);
    chk("t3_blocked", mem[8'h08], 32'hADAD0808);
    step(1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 8'h0, 32'h0);
    chk("t3_ack_rdata", s_rdata, 32'hA6A60303);
    chk("t3_landed", mem[8'h08], 32'h12345678);

    // 4: request held high, core idle: grants alternate with acks.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'(k), 32'h0);
      chk("t4_gnt", s_gnt, (k % 2 == 0));
      chk("t4_ack", s_ack, (k % 2 == 1));
    end
    idle();

    // 5: abort after two waiting cycles, then a fresh request waits the full bound again.
    for (int k = 0; k < 2; k++)
      step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h07, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h07, 32'h0);
    chk("t5_abort_gnt", s_gnt, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h07, 32'h0);
    chk("t5_abort_ack", s_ack, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h07, 32'h0);
      chk("t5_regnt", s_gnt, (k == 5));
    end

    // 6: reset while the ack is due drops it; the core write during reset is not performed.
    idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 8'h30, 32'hCAFEF00D);
    chk("t6_gnt", s_gnt, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0, 8'h0, 32'h0);
    chk("t6_rst_we", s_we, 1'b0);
    idle();
    chk("t6_ack", s_ack, 1'b0);
    chk("t6_rdata", s_rdata, 32'h0);
    chk("t6_perf", s_perf_ext, 32'h0);
    chk("t6_mem0", mem[8'h00], 32'hA5A50000);
    chk("t6_mem30", mem[8'h30], 32'hCAFEF00D);

    // Randomized run; the external master obeys hold-until-grant but may abort.
    r_req = 1'b0; r_we = 1'b0; r_addr = '0; r_wd = '0;
    for (int n = 0; n < 4000; n++) begin
      if (!r_req || s_gnt) begin
        r_req  = ($urandom_range(0, 2) == 0);
        r_we   = $urandom_range(0, 1) == 1;
        r_addr = 8'($urandom_range(0, 15));
        r_wd   = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        r_req = 1'b0;
      end
      c_re   = ($urandom_range(0, 9) < 5);
      c_we   = !c_re && ($urandom_range(0, 9) < 4);
      c_addr = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      step(($urandom_range(0, 199) != 0), c_re, c_we, c_addr, $urandom,
           r_req, r_we, r_addr, r_wd);
    end

    for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
